// File: rtl/subtractor_serial_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package subtractor_serial_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/addbit.sv
// Single-bit full adder: combinational, zero latency, no flow control.
module addbit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor computing r1 - r2 - bi LSB first; done pulses WIDTH+1 cycles after start.
// start is only sampled in IDLE; requests while busy are dropped, never queued.
module subtractor_serial
    import subtractor_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_b;
    logic             fa_sum;
    logic             fa_co;
    logic [WIDTH-1:0] sh_next;

    // Subtraction as a + ~b + ~bi: the borrow-in is folded into the initial carry.
    assign fa_b = ~b_q[0];

    addbit u_addbit (
        .a   (a_q[0]),
        .b   (fa_b),
        .ci  (carry_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        result_d = result_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        sh_next  = sh_q >> 1;
        sh_next[WIDTH-1] = fa_sum;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = r1;
                    b_d     = r2;
                    carry_d = ~bi;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sh_d    = sh_next;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                // Only the completed word is published, so result never shows partial shifts.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = sh_next;
                    borrow_d = ~fa_co;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign borrow = borrow_q;

endmodule

// File: doc/subtractor_serial.md
SUBTRACTOR_SERIAL -- requirements
Module: subtractor_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port r1, input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 The block SHALL have port r2, input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port bi, input, 1 bit: borrow input, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result and borrow valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: r1 - r2 - bi, modulo 2^WIDTH.
REQ-011 The block SHALL have port borrow, output, 1 bit: high when r1 < r2 + bi (unsigned).

Function
REQ-012 The block SHALL compute the difference bit-serially, LSB first, one bit per clock, as r1 + ~r2 + ~bi through a single full adder.
REQ-013 The state machine SHALL have states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on start.
- SHIFT -> DONE after exactly WIDTH bit cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-014 Start accepted at edge N SHALL:
- load the operand registers;
- load the carry register with ~bi;
- clear the bit counter;
- cause busy to be high from cycle N+1 through cycle N+WIDTH.
REQ-015 In SHIFT, each edge SHALL:
- shift one sum bit into the result register from the MSB side;
- update the carry register with the full-adder carry-out;
- increment the bit counter.
The counter SHALL be ceil(log2(WIDTH+1)) bits wide.
REQ-016 In DONE, the block SHALL drive done high for exactly one cycle (cycle N+WIDTH+1) and SHALL drive busy low in that cycle; latency from accepted start to done is WIDTH+1 cycles.
REQ-017 borrow SHALL equal the inverse of the final carry register value and SHALL be updated only on the edge leaving SHIFT.
REQ-018 result and borrow SHALL hold their last completed values until the next start is accepted; intermediate shift values SHALL NOT appear on result.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored; no queuing.
REQ-020 r1, r2 and bi changing after acceptance SHALL NOT affect the operation in flight.
REQ-021 start held high continuously SHALL begin a new operation on the first IDLE cycle after each DONE, giving back-to-back operations every WIDTH+2 cycles.

Reset
REQ-022 Reset high at an edge SHALL force IDLE and clear busy, done, result, borrow, the counter and all operand and carry registers to 0.
REQ-023 Reset SHALL take priority over start, and an operation interrupted by reset SHALL produce no done pulse.
REQ-024 The first start SHALL be accepted on the first edge where reset is low.

Structure
REQ-025 Package subtractor_serial_pkg SHALL hold the state enumeration type and the default WIDTH constant.
REQ-026 The full adder SHALL be the existing addbit module, instantiated exactly once with ports a, b, ci, sum, co; no other sub-modules.

Verification
REQ-027 Reset, then r1=10, r2=2, bi=0, start -> done 5 cycles after accept; result=8, borrow=0.
REQ-028 r1=2, r2=10, bi=0 -> result=8, borrow=1.
REQ-029 r1=5, r2=5, bi=1 -> result=15, borrow=1; then r1=0, r2=0, bi=0 -> result=0, borrow=0.
REQ-030 start pulsed again in SHIFT with r1=15 -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-031 Reset asserted in the 2nd SHIFT cycle -> next cycle busy=0, result=0, borrow=0, and no done pulse.
REQ-032 Exhaustive check of all 512 (r1, r2, bi) combinations against a reference model -> zero mismatches; the bench SHALL also check the busy/done timing on every operation.
